mips_control_fsm: RTL and testbench
===================================

// Module: mips_control_fsm
// PURPOSE
//  Multicycle MIPS main control FSM. Decodes opcode/funct from the instruction register and
//  sequences FETCH/DECODE/EXEC/MEM/WB. Drives every datapath select, including ALUSrcB into
//  the ALU B-input mux, plus register, memory and PC write enables.
//  Stalls on Avalon waitrequest. Halts on a jump to address 0.
// PARAMETERS
//  ALUOP_W    2   width of alu_op (0=ADD, 1=SUB, 2=FUNCT, 3=IMM)
//  PCSRC_W    2   width of pc_source (0=ALU, 1=ALUOut, 2=jump target, 3=reg A)
// PORTS
//  clk             in   1        rising-edge clock
//  reset           in   1        asynchronous, active-low
//  opcode          in   6        instr[31:26] from IR (valid from DECODE onward)
//  funct           in   6        instr[5:0] from IR
//  waitrequest     in   1        Avalon stall for the current read/write
//  alu_zero        in   1        ALU zero flag (used in EXEC for branches)
//  jump_target_zero in  1        computed jump/jr target == 32'h0
//  active          out  1        1 while executing; 0 once halted
//  iord            out  1        0 = PC addresses memory, 1 = ALUOut addresses memory
//  mem_read        out  1        Avalon read strobe
//  mem_write       out  1        Avalon write strobe
//  ir_write        out  1        latch readdata into IR
//  reg_write       out  1        register-file write enable
//  reg_dst         out  1        0 = rt, 1 = rd
//  mem_to_reg      out  1        0 = ALUOut, 1 = MDR
//  alu_src_a       out  1        0 = PC, 1 = reg A
//  alu_src_b       out  2        0 = reg B, 1 = const 4, 2 = ext imm, 3 = ext imm<<2
//  alu_op          out  ALUOP_W  ALU operation class
//  pc_write        out  1        unconditional PC write
//  pc_write_cond   out  1        PC write if branch condition holds
//  branch_ne       out  1        1 = BNE (condition is !alu_zero), 0 = BEQ
//  pc_source       out  PCSRC_W  PC next-value select
// BEHAVIOUR
//  - Registered state only. All outputs are a Moore decode of state plus IR fields.
//    Strobes are high only in the listed states.
//  - reset low: state = FETCH and active = 1, immediately. Fetch starts on the first edge
//    after release. All other outputs are 0 in reset.
//  - FETCH: iord=0, mem_read=1, alu_src_a=0, alu_src_b=1, alu_op=ADD.
//    If waitrequest: hold. Otherwise: ir_write=1, pc_write=1, pc_source=0, then go to DECODE.
//  - DECODE: alu_src_a=0, alu_src_b=3, alu_op=ADD (precompute branch target), then EXEC.
//  - EXEC, by class:
//    R-type (op 0, funct != JR): a=1, b=0, op=FUNCT -> WB.
//    JR (op 0, funct 001000): pc_write=1, pc_source=3 -> FETCH, or HALT if jump_target_zero.
//    I-ALU (ADDIU/ANDI/ORI/XORI/SLTI/SLTIU): a=1, b=2, op=IMM -> WB.
//    LW/SW: a=1, b=2, op=ADD -> MEM.
//    BEQ/BNE: a=1, b=0, op=SUB, pc_write_cond=1, pc_source=1, branch_ne per opcode -> FETCH.
//    J/JAL: pc_write=1, pc_source=2 -> FETCH, or HALT if jump_target_zero.
//    JAL link write is out of scope here.
//    Unknown opcode: no writes (NOP) -> FETCH.
//  - MEM: iord=1. LW: mem_read=1. SW: mem_write=1. Hold while waitrequest.
//    On release: LW -> WB, SW -> FETCH. Strobe and address stay stable during the stall.
//  - WB: reg_write=1 for exactly one cycle. R: reg_dst=1, mem_to_reg=0.
//    I-ALU: reg_dst=0, mem_to_reg=0. LW: reg_dst=0, mem_to_reg=1. Then FETCH.
//  - HALT: active=0, every strobe and enable 0. Sticky until reset.
//  - Latency (no stalls): R/I 4 cycles, LW 5, SW 4, branch/jump 3.
//  - Reset mid-stall (e.g. MEM waiting): abort with no write, return to FETCH.
//  - mem_read and mem_write are never both 1. ir_write only in FETCH.
//    Unreachable state encodings return to FETCH.
// STRUCTURE
//  - Shared package mips_pkg: opcode_t enum (incl. ANDI/ORI/XORI), FUNCT_JR, state_t,
//    alu_src_b_t {SRCB_REG, SRCB_FOUR, SRCB_IMM, SRCB_IMM_SH2}, alu_op_t, pc_source_t.
//    The ALU B-mux imports the same alu_src_b_t.
//  - One combinational sub-module, mips_instr_class, maps opcode/funct to
//    {RTYPE, JR, IALU, LOAD, STORE, BRANCH, JUMP, UNKNOWN}.
//  - The FSM file holds the state register and output decode only.
// TESTING
//  1. ADDU (op 0, funct 100001), waitrequest=0: states F,D,E,W.
//     alu_src_b = 1,3,0,x; reg_write=1 only in cycle 4 with reg_dst=1.
//  2. LW (op 100011), waitrequest high 3 cycles in MEM: mem_read=1, iord=1 held for 4 cycles.
//     Then WB with mem_to_reg=1. ir_write never asserted outside FETCH.
//  3. BNE (op 000101): EXEC shows pc_write_cond=1, branch_ne=1, alu_op=SUB, pc_source=1.
//     The next cycle is FETCH.
//  4. JR (op 0, funct 001000) with jump_target_zero=1: HALT the next cycle.
//     active=0; all strobes stay 0 for 10 more cycles despite any opcode change.
//  5. Reset pulled low in the middle of a SW stall: mem_write drops asynchronously.
//     After release: FETCH, active=1, mem_read=1.
//  6. Opcode 111111: F,D,E then F with no reg_write, mem_write or pc_write in EXEC.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared types for the multicycle MIPS control path: opcodes, FSM states,
// instruction classes and the datapath select encodings.
package mips_pkg;

    typedef enum logic [5:0] {
        OP_RTYPE = 6'b000000,
        OP_J     = 6'b000010,
        OP_JAL   = 6'b000011,
        OP_BEQ   = 6'b000100,
        OP_BNE   = 6'b000101,
        OP_ADDIU = 6'b001001,
        OP_SLTI  = 6'b001010,
        OP_SLTIU = 6'b001011,
        OP_ANDI  = 6'b001100,
        OP_ORI   = 6'b001101,
        OP_XORI  = 6'b001110,
        OP_LW    = 6'b100011,
        OP_SW    = 6'b101011
    } opcode_t;

    localparam logic [5:0] FUNCT_JR = 6'b001000;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        CLS_RTYPE,
        CLS_JR,
        CLS_IALU,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_JUMP,
        CLS_UNKNOWN
    } instr_class_t;

    typedef enum logic [1:0] {
        SRCB_REG     = 2'd0,
        SRCB_FOUR    = 2'd1,
        SRCB_IMM     = 2'd2,
        SRCB_IMM_SH2 = 2'd3
    } alu_src_b_t;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'd0,
        ALU_SUB   = 2'd1,
        ALU_FUNCT = 2'd2,
        ALU_IMM   = 2'd3
    } alu_op_t;

    typedef enum logic [1:0] {
        PCS_ALU    = 2'd0,
        PCS_ALUOUT = 2'd1,
        PCS_JUMP   = 2'd2,
        PCS_REGA   = 2'd3
    } pc_source_t;

endpackage

// File: rtl/mips_instr_class.sv
// Combinational opcode/funct classifier feeding the control FSM.
module mips_instr_class
    import mips_pkg::*;
(
    input  logic [5:0]   opcode,
    input  logic [5:0]   funct,
    output instr_class_t iclass
);

    always_comb begin
        iclass = CLS_UNKNOWN;
        case (opcode)
            OP_RTYPE: iclass = (funct == FUNCT_JR) ? CLS_JR : CLS_RTYPE;
            OP_ADDIU, OP_SLTI, OP_SLTIU,
            OP_ANDI, OP_ORI, OP_XORI: iclass = CLS_IALU;
            OP_LW:           iclass = CLS_LOAD;
            OP_SW:           iclass = CLS_STORE;
            OP_BEQ, OP_BNE:  iclass = CLS_BRANCH;
            OP_J, OP_JAL:    iclass = CLS_JUMP;
            default:         iclass = CLS_UNKNOWN;
        endcase
    end

endmodule

// File: rtl/mips_control_fsm.sv
// Multicycle MIPS main control: state register plus a Moore decode of state and
// instruction class into every datapath select and write enable.
module mips_control_fsm
    import mips_pkg::*;
#(
    parameter int ALUOP_W = 2,
    parameter int PCSRC_W = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic               waitrequest,
    input  logic               alu_zero,
    input  logic               jump_target_zero,
    output logic               active,
    output logic               iord,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               reg_write,
    output logic               reg_dst,
    output logic               mem_to_reg,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               pc_write,
    output logic               pc_write_cond,
    output logic               branch_ne,
    output logic [PCSRC_W-1:0] pc_source
);

    state_t       state_reg;
    instr_class_t iclass;
    alu_src_b_t   alu_src_b_c;
    alu_op_t      alu_op_c;
    pc_source_t   pc_source_c;

    mips_instr_class u_class (
        .opcode (opcode),
        .funct  (funct),
        .iclass (iclass)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= S_FETCH;
        end else begin
            case (state_reg)
                S_FETCH:  if (!waitrequest) state_reg <= S_DECODE;
                S_DECODE: state_reg <= S_EXEC;
                S_EXEC: begin
                    case (iclass)
                        CLS_RTYPE, CLS_IALU:  state_reg <= S_WB;
                        CLS_LOAD, CLS_STORE:  state_reg <= S_MEM;
                        CLS_JR, CLS_JUMP:     state_reg <= jump_target_zero ? S_HALT : S_FETCH;
                        default:              state_reg <= S_FETCH;
                    endcase
                end
                S_MEM: begin
                    if (!waitrequest)
                        state_reg <= (iclass == CLS_LOAD) ? S_WB : S_FETCH;
                end
                S_WB:     state_reg <= S_FETCH;
                S_HALT:   state_reg <= S_HALT;
                default:  state_reg <= S_FETCH;
            endcase
        end
    end

    // Outputs are masked by reset so an in-flight memory strobe drops the
    // moment reset is asserted, without waiting for a clock edge.
    always_comb begin
        active        = (state_reg != S_HALT);
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b_c   = SRCB_REG;
        alu_op_c      = ALU_ADD;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        branch_ne     = 1'b0;
        pc_source_c   = PCS_ALU;
        if (reset) begin
            case (state_reg)
                S_FETCH: begin
                    mem_read    = 1'b1;
                    alu_src_b_c = SRCB_FOUR;
                    ir_write    = !waitrequest;
                    pc_write    = !waitrequest;
                end
                S_DECODE: alu_src_b_c = SRCB_IMM_SH2;
                S_EXEC: begin
                    case (iclass)
                        CLS_RTYPE: begin
                            alu_src_a = 1'b1;
                            alu_op_c  = ALU_FUNCT;
                        end
                        CLS_IALU: begin
                            alu_src_a   = 1'b1;
                            alu_src_b_c = SRCB_IMM;
                            alu_op_c    = ALU_IMM;
                        end
                        CLS_LOAD, CLS_STORE: begin
                            alu_src_a   = 1'b1;
                            alu_src_b_c = SRCB_IMM;
                        end
                        CLS_BRANCH: begin
                            alu_src_a     = 1'b1;
                            alu_op_c      = ALU_SUB;
                            pc_write_cond = 1'b1;
                            pc_source_c   = PCS_ALUOUT;
                            branch_ne     = (opcode == OP_BNE);
                        end
                        CLS_JUMP: begin
                            pc_write    = 1'b1;
                            pc_source_c = PCS_JUMP;
                        end
                        CLS_JR: begin
                            pc_write    = 1'b1;
                            pc_source_c = PCS_REGA;
                        end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    iord      = 1'b1;
                    mem_read  = (iclass == CLS_LOAD);
                    mem_write = (iclass == CLS_STORE);
                end
                S_WB: begin
                    reg_write  = 1'b1;
                    reg_dst    = (iclass == CLS_RTYPE);
                    mem_to_reg = (iclass == CLS_LOAD);
                end
                default: ;
            endcase
        end
    end

    assign alu_src_b = alu_src_b_c;
    assign alu_op    = ALUOP_W'(alu_op_c);
    assign pc_source = PCSRC_W'(pc_source_c);

    // The datapath resolves the branch from alu_zero; it must be a real value then.
    assert property (@(posedge clk) disable iff (!reset) !(mem_read && mem_write));
    assert property (@(posedge clk) disable iff (!reset)
        (state_reg == S_EXEC && iclass == CLS_BRANCH) |-> !$isunknown(alu_zero));

endmodule

// File: tb/tb_mips_control_fsm.sv
// Directed-vector bench for mips_control_fsm: one task per instruction scenario.
module tb_mips_control_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       waitrequest;
    logic       alu_zero;
    logic       jump_target_zero;
    logic       active, iord, mem_read, mem_write, ir_write, reg_write;
    logic       reg_dst, mem_to_reg, alu_src_a, pc_write, pc_write_cond, branch_ne;
    logic [1:0] alu_src_b, alu_op, pc_source;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mips_control_fsm dut (
        .clk              (clk),
        .reset            (reset),
        .opcode           (opcode),
        .funct            (funct),
        .waitrequest      (waitrequest),
        .alu_zero         (alu_zero),
        .jump_target_zero (jump_target_zero),
        .active           (active),
        .iord             (iord),
        .mem_read         (mem_read),
        .mem_write        (mem_write),
        .ir_write         (ir_write),
        .reg_write        (reg_write),
        .reg_dst          (reg_dst),
        .mem_to_reg       (mem_to_reg),
        .alu_src_a        (alu_src_a),
        .alu_src_b        (alu_src_b),
        .alu_op           (alu_op),
        .pc_write         (pc_write),
        .pc_write_cond    (pc_write_cond),
        .branch_ne        (branch_ne),
        .pc_source        (pc_source)
    );

    // {active,iord,mem_read,mem_write,ir_write,reg_write,reg_dst,mem_to_reg,
    //  alu_src_a,alu_src_b[2],alu_op[2],pc_write,pc_write_cond,branch_ne,pc_source[2]}
    logic [17:0] obs;
    assign obs = {active, iord, mem_read, mem_write, ir_write, reg_write, reg_dst,
                  mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_write, pc_write_cond,
                  branch_ne, pc_source};

    localparam logic [17:0] E_RESET     = {9'b1_0000_0000, 2'd0, 2'd0, 3'b000, 2'd0};
    localparam logic [17:0] E_FETCH     = {9'b1_0101_0000, 2'd1, 2'd0, 3'b100, 2'd0};
    localparam logic [17:0] E_DECODE    = {9'b1_0000_0000, 2'd3, 2'd0, 3'b000, 2'd0};
    localparam logic [17:0] E_EXEC_R    = {9'b1_0000_0001, 2'd0, 2'd2, 3'b000, 2'd0};
    localparam logic [17:0] E_EXEC_I    = {9'b1_0000_0001, 2'd2, 2'd3, 3'b000, 2'd0};
    localparam logic [17:0] E_EXEC_MEM  = {9'b1_0000_0001, 2'd2, 2'd0, 3'b000, 2'd0};
    localparam logic [17:0] E_EXEC_BNE  = {9'b1_0000_0001, 2'd0, 2'd1, 3'b011, 2'd1};
    localparam logic [17:0] E_EXEC_BEQ  = {9'b1_0000_0001, 2'd0, 2'd1, 3'b010, 2'd1};
    localparam logic [17:0] E_EXEC_J    = {9'b1_0000_0000, 2'd0, 2'd0, 3'b100, 2'd2};
    localparam logic [17:0] E_EXEC_JR   = {9'b1_0000_0000, 2'd0, 2'd0, 3'b100, 2'd3};
    localparam logic [17:0] E_EXEC_NOP  = {9'b1_0000_0000, 2'd0, 2'd0, 3'b000, 2'd0};
    localparam logic [17:0] E_MEM_LW    = {9'b1_1100_0000, 2'd0, 2'd0, 3'b000, 2'd0};
    localparam logic [17:0] E_MEM_SW    = {9'b1_1010_0000, 2'd0, 2'd0, 3'b000, 2'd0};
    localparam logic [17:0] E_WB_R      = {9'b1_0000_1100, 2'd0, 2'd0, 3'b000, 2'd0};
    localparam logic [17:0] E_WB_I      = {9'b1_0000_1000, 2'd0, 2'd0, 3'b000, 2'd0};
    localparam logic [17:0] E_WB_LW     = {9'b1_0000_1010, 2'd0, 2'd0, 3'b000, 2'd0};
    localparam logic [17:0] E_HALT      = {9'b0_0000_0000, 2'd0, 2'd0, 3'b000, 2'd0};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tick();
        tick();
        checks++;
        if (obs !== E_RESET) begin
            errors++;
            $display("FAIL reset_hold obs=%b exp=%b", obs, E_RESET);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (obs !== E_FETCH) begin
            errors++;
            $display("FAIL reset_release obs=%b exp=%b", obs, E_FETCH);
        end
        $display("reset: released into FETCH");
    endtask

    task automatic test_addu();
        logic [17:0] exp_seq [5];
        exp_seq = '{E_FETCH, E_DECODE, E_EXEC_R, E_WB_R, E_FETCH};
        opcode = 6'b000000;
        funct  = 6'b100001;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (obs !== exp_seq[i]) begin
                errors++;
                $display("FAIL addu[%0d] obs=%b exp=%b", i, obs, exp_seq[i]);
            end
            if (i < 4) tick();
        end
        $display("addu: F D E W");
    endtask

    task automatic test_ori();
        logic [17:0] exp_seq [5];
        exp_seq = '{E_FETCH, E_DECODE, E_EXEC_I, E_WB_I, E_FETCH};
        opcode = 6'b001101;
        funct  = 6'b000000;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (obs !== exp_seq[i]) begin
                errors++;
                $display("FAIL ori[%0d] obs=%b exp=%b", i, obs, exp_seq[i]);
            end
            if (i < 4) tick();
        end
        $display("ori: F D E W");
    endtask

    task automatic test_lw_stall();
        logic [17:0] exp_seq [3];
        exp_seq = '{E_FETCH, E_DECODE, E_EXEC_MEM};
        opcode = 6'b100011;
        funct  = 6'b000000;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs !== exp_seq[i]) begin
                errors++;
                $display("FAIL lw[%0d] obs=%b exp=%b", i, obs, exp_seq[i]);
            end
            tick();
        end
        for (int k = 0; k < 4; k++) begin
            waitrequest = (k < 3);
            checks++;
            if (obs !== E_MEM_LW) begin
                errors++;
                $display("FAIL lw_mem[%0d] obs=%b exp=%b", k, obs, E_MEM_LW);
            end
            tick();
        end
        checks++;
        if (obs !== E_WB_LW) begin
            errors++;
            $display("FAIL lw_wb obs=%b exp=%b", obs, E_WB_LW);
        end
        tick();
        checks++;
        if (obs !== E_FETCH) begin
            errors++;
            $display("FAIL lw_next obs=%b exp=%b", obs, E_FETCH);
        end
        $display("lw: F D E M*4 W");
    endtask

    task automatic test_branches();
        logic [17:0] bne_seq [4];
        logic [17:0] beq_seq [4];
        bne_seq = '{E_FETCH, E_DECODE, E_EXEC_BNE, E_FETCH};
        beq_seq = '{E_FETCH, E_DECODE, E_EXEC_BEQ, E_FETCH};
        opcode   = 6'b000101;
        alu_zero = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs !== bne_seq[i]) begin
                errors++;
                $display("FAIL bne[%0d] obs=%b exp=%b", i, obs, bne_seq[i]);
            end
            if (i < 3) tick();
        end
        $display("bne: F D E");
        opcode   = 6'b000100;
        alu_zero = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs !== beq_seq[i]) begin
                errors++;
                $display("FAIL beq[%0d] obs=%b exp=%b", i, obs, beq_seq[i]);
            end
            if (i < 3) tick();
        end
        $display("beq: F D E");
    endtask

    task automatic test_jump();
        logic [17:0] exp_seq [4];
        exp_seq = '{E_FETCH, E_DECODE, E_EXEC_J, E_FETCH};
        opcode           = 6'b000010;
        jump_target_zero = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs !== exp_seq[i]) begin
                errors++;
                $display("FAIL j[%0d] obs=%b exp=%b", i, obs, exp_seq[i]);
            end
            if (i < 3) tick();
        end
        $display("j: F D E (nonzero target)");
    endtask

    task automatic test_unknown();
        logic [17:0] exp_seq [4];
        exp_seq = '{E_FETCH, E_DECODE, E_EXEC_NOP, E_FETCH};
        opcode = 6'b111111;
        funct  = 6'b000000;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs !== exp_seq[i]) begin
                errors++;
                $display("FAIL unknown[%0d] obs=%b exp=%b", i, obs, exp_seq[i]);
            end
            if (i < 3) tick();
        end
        $display("unknown: F D E as NOP");
    endtask

    task automatic test_sw_reset();
        logic [17:0] exp_seq [3];
        exp_seq = '{E_FETCH, E_DECODE, E_EXEC_MEM};
        opcode = 6'b101011;
        funct  = 6'b000000;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs !== exp_seq[i]) begin
                errors++;
                $display("FAIL sw[%0d] obs=%b exp=%b", i, obs, exp_seq[i]);
            end
            tick();
        end
        waitrequest = 1'b1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs !== E_MEM_SW) begin
                errors++;
                $display("FAIL sw_mem[%0d] obs=%b exp=%b", k, obs, E_MEM_SW);
            end
            if (k < 1) tick();
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (mem_write !== 1'b0 || obs !== E_RESET) begin
            errors++;
            $display("FAIL sw_async_reset obs=%b exp=%b", obs, E_RESET);
        end
        tick();
        checks++;
        if (obs !== E_RESET) begin
            errors++;
            $display("FAIL sw_reset_hold obs=%b exp=%b", obs, E_RESET);
        end
        reset       = 1'b1;
        waitrequest = 1'b0;
        #1;
        checks++;
        if (obs !== E_FETCH) begin
            errors++;
            $display("FAIL sw_after_reset obs=%b exp=%b", obs, E_FETCH);
        end
        $display("sw: stall aborted by reset, back in FETCH");
    endtask

    task automatic test_jr_halt();
        logic [17:0] exp_seq [4];
        exp_seq = '{E_FETCH, E_DECODE, E_EXEC_JR, E_HALT};
        opcode           = 6'b000000;
        funct            = 6'b001000;
        jump_target_zero = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs !== exp_seq[i]) begin
                errors++;
                $display("FAIL jr[%0d] obs=%b exp=%b", i, obs, exp_seq[i]);
            end
            if (i < 3) tick();
        end
        for (int k = 1; k <= 10; k++) begin
            opcode           = 6'(k * 5);
            funct            = 6'(k);
            waitrequest      = k[0];
            jump_target_zero = 1'b0;
            tick();
            checks++;
            if (obs !== E_HALT) begin
                errors++;
                $display("FAIL halt_sticky[%0d] obs=%b exp=%b", k, obs, E_HALT);
            end
        end
        $display("jr: target zero, halted for 10 cycles");
    endtask

    initial begin
        reset            = 1'b0;
        opcode           = 6'b000000;
        funct            = 6'b000000;
        waitrequest      = 1'b0;
        alu_zero         = 1'b0;
        jump_target_zero = 1'b0;
        test_reset();
        test_addu();
        test_lw_stall();
        test_ori();
        test_branches();
        test_jump();
        test_unknown();
        test_sw_reset();
        test_jr_halt();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
